// File: rtl/btm_pkg.sv
// Shared definitions for the balanced-ternary (BTM) family.
// Covers trit encodings, the decoder FSM states and a magnitude helper.
package btm_pkg;

  localparam logic [1:0] TRIT_NEG  = 2'b01;
  localparam logic [1:0] TRIT_ZERO = 2'b11;
  localparam logic [1:0] TRIT_POS  = 2'b10;
  localparam logic [1:0] TRIT_ILL  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } btm_state_t;

  // Largest magnitude an n-trit balanced-ternary word can represent: (3^n-1)/2.
  function automatic int max_mag(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 3;
    return (p - 1) / 2;
  endfunction

endpackage

// File: rtl/btm_trit_decode.sv
// Maps one 2-bit trit code to a signed digit and an illegal-code flag.
// Purely combinational, so it has zero latency and no backpressure.
module btm_trit_decode
  import btm_pkg::*;
(
  input  logic [1:0]        code,
  output logic signed [1:0] digit,
  output logic              illegal
);

  always_comb begin
    digit   = '0;
    illegal = 1'b0;
    case (code)
      TRIT_NEG:  digit   = -2'sd1;
      TRIT_POS:  digit   = 2'sd1;
      TRIT_ZERO: digit   = 2'sd0;
      TRIT_ILL:  illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/btm_result_decoder.sv
// Converts an NTRITS balanced-ternary word to two's complement, one trit per cycle, MSB first.
// out_valid rises NTRITS cycles after accept; the result is held until out_ready, and the block accepts input only in IDLE.
module btm_result_decoder
  import btm_pkg::*;
#(
  parameter int NTRITS = 4,
  parameter int OUT_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NTRITS-1:0]   in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_value,
  output logic                  out_illegal,
  output logic                  busy
);

  localparam int W     = 2 * NTRITS;
  localparam int CNT_W = (NTRITS > 1) ? $clog2(NTRITS) : 1;

  btm_state_t state_q, state_d;

  logic [W-1:0]             sreg_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [OUT_W-1:0]  acc_q;
  logic                     ill_q;

  logic signed [1:0]        digit;
  logic                     code_ill;
  logic signed [OUT_W+1:0]  acc_ext;
  logic signed [OUT_W+1:0]  acc3;
  logic signed [OUT_W-1:0]  acc_nxt;
  logic                     ill_nxt;
  logic                     last_trit;

  btm_trit_decode u_trit_decode (
    .code    (sreg_q[W-1 -: 2]),
    .digit   (digit),
    .illegal (code_ill)
  );

  // Horner step: acc*3 + digit, computed wide then truncated back to OUT_W.
  always_comb begin
    acc_ext   = {{2{acc_q[OUT_W-1]}}, acc_q};
    acc3      = (acc_ext <<< 1) + acc_ext + {{OUT_W{digit[1]}}, digit};
    acc_nxt   = acc3[OUT_W-1:0];
    ill_nxt   = ill_q | code_ill;
    last_trit = (cnt_q == CNT_W'(NTRITS - 1));
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CONV;
      CONV:    if (last_trit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ill_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sreg_q <= in_word;
            cnt_q  <= '0;
            acc_q  <= '0;
            ill_q  <= 1'b0;
          end
        end
        CONV: begin
          acc_q  <= acc_nxt;
          ill_q  <= ill_nxt;
          sreg_q <= sreg_q << 2;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_trit) begin
            out_value   <= acc_nxt;
            out_illegal <= ill_nxt;
            out_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btm_result_decoder.sv
// Directed bench for btm_result_decoder with hand-computed ternary vectors.
module tb_btm_result_decoder;
  import btm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_word = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] out_value;
  logic       out_illegal;
  logic       busy;

  int tests = 0;
  int fails = 0;

  btm_result_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Offers one word, returns cycles from accept to out_valid and the observed result.
  task automatic xfer(input logic [7:0] w, output int lat, output logic [6:0] val,
                      output logic ill, output int rdy_hi);
    int n;
    lat = -1; val = '0; ill = 1'b0; rdy_hi = 0; n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) return;
    in_valid = 1'b1; in_word = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1; lat++;
    end
    val = out_value;
    ill = out_illegal;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, busy, out_valid, out_illegal, out_value} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'h00}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b busy=%b vld=%b ill=%b val=0x%0h expected 1 0 0 0 0x0",
               in_ready, busy, out_valid, out_illegal, out_value);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release_idle: rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat, rh; logic [6:0] v; logic il;
    out_ready = 1'b1;
    xfer(8'h96, lat, v, il, rh);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    tests++;
    if (v !== 7'h10 || il !== 1'b0) begin
      fails++; $display("FAIL basic_value: got 0x%0h ill=%b expected 0x10 ill=0", v, il);
    end
    @(posedge clk); #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL basic_handoff: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    logic [7:0] words [3] = '{8'h69, 8'hDB, 8'hFF};
    logic [6:0] exps  [3] = '{7'h70, 7'h7A, 7'h00};
    int lat, rh; logic [6:0] v; logic il;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(words[i], lat, v, il, rh);
      tests++;
      if (lat !== 4 || v !== exps[i] || il !== 1'b0) begin
        fails++;
        $display("FAIL signed_%0d: word=0x%0h lat=%0d val=0x%0h ill=%b expected lat=4 val=0x%0h ill=0",
                 i, words[i], lat, v, il, exps[i]);
      end
      tests++;
      if (rh !== 0) begin fails++; $display("FAIL signed_busy_ready_%0d: in_ready high %0d cycles, expected 0", i, rh); end
    end
  endtask

  task automatic test_extremes();
    int lat, rh; logic [6:0] v; logic il;
    logic [6:0] pmax, nmax;
    pmax = 7'(max_mag(4));
    nmax = 7'(-max_mag(4));
    out_ready = 1'b1;
    xfer(8'hAA, lat, v, il, rh);
    tests++;
    if (v !== pmax || v !== 7'b0101000 || il !== 1'b0) begin
      fails++; $display("FAIL extreme_pos: got 0x%0h ill=%b expected 0x28 ill=0", v, il);
    end
    xfer(8'h55, lat, v, il, rh);
    tests++;
    if (v !== nmax || v !== 7'b1011000 || il !== 1'b0) begin
      fails++; $display("FAIL extreme_neg: got 0x%0h ill=%b expected 0x58 ill=0", v, il);
    end
    xfer(8'h00, lat, v, il, rh);
    tests++;
    if (v !== 7'h00 || il !== 1'b1) begin
      fails++; $display("FAIL all_illegal: got 0x%0h ill=%b expected 0x0 ill=1", v, il);
    end
  endtask

  task automatic test_illegal();
    int lat, rh; logic [6:0] v; logic il;
    out_ready = 1'b1;
    xfer(8'h3F, lat, v, il, rh);
    tests++;
    if (v !== 7'h00 || il !== 1'b1) begin
      fails++; $display("FAIL illegal_top: got 0x%0h ill=%b expected 0x0 ill=1", v, il);
    end
    xfer(8'hFF, lat, v, il, rh);
    tests++;
    if (v !== 7'h00 || il !== 1'b0) begin
      fails++; $display("FAIL illegal_clears: got 0x%0h ill=%b expected 0x0 ill=0", v, il);
    end
  endtask

  task automatic test_backpressure();
    int lat, rh; logic [6:0] v; logic il;
    @(posedge clk); #1;
    out_ready = 1'b0;
    xfer(8'hDB, lat, v, il, rh);
    tests++;
    if (lat !== 4 || v !== 7'h7A) begin
      fails++; $display("FAIL bp_result: lat=%0d val=0x%0h expected lat=4 val=0x7a", lat, v);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_word = 8'h96;
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready} !== 2'b10 || out_value !== 7'h7A) begin
        fails++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b val=0x%0h expected 1 0 0x7a", i, out_valid, in_ready, out_value);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, in_ready, busy} !== 3'b010 || out_value !== 7'h7A) begin
      fails++;
      $display("FAIL bp_no_capture: vld=%b rdy=%b busy=%b val=0x%0h expected 0 1 0 0x7a",
               out_valid, in_ready, busy, out_value);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rh; logic [6:0] v; logic il;
    logic seen;
    seen = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_word = 8'h96;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: busy=%b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, busy, out_valid, out_illegal, out_value} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'h00}) begin
      fails++;
      $display("FAIL mid_async_reset: rdy=%b busy=%b vld=%b ill=%b val=0x%0h expected 1 0 0 0 0x0",
               in_ready, busy, out_valid, out_illegal, out_value);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_output: out_valid seen=%b expected 0", seen); end
    xfer(8'h69, lat, v, il, rh);
    tests++;
    if (lat !== 4 || v !== 7'h70 || il !== 1'b0) begin
      fails++; $display("FAIL mid_after_reset: lat=%0d val=0x%0h ill=%b expected 4 0x70 0", lat, v, il);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
